matmul_job_controller: RTL and testbench

Top-level sequencer for one weight-stationary NxN systolic matrix job. It accepts a start request and runs four phases in order: weight load, skewed data streaming, pipeline drain, and per-row result hand-off. It sits between the host-side handshake (input_ready/output_ready) and the skewer/array enables. It drives the array's load_weight and enable_mult controls and the skewer enable.

---
 rtl/matmul_job_controller_if.sv | 45 ++++
 rtl/matmul_job_controller.sv | 108 ++++++++++
 tb/tb_matmul_job_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_job_controller_if.sv
// rtl/matmul_job_controller_if.sv - host/array handshake bundle for the matmul job controller
interface matmul_job_controller_if #(
  parameter int MATRIX_SIZE = 2
);
  localparam int ROW_W = $clog2(MATRIX_SIZE);

  logic                   start;
  logic                   input_ready;
  logic                   output_ready;
  logic                   module_ready;
  logic [MATRIX_SIZE-1:0] load_weight;
  logic                   skew_enable;
  logic [MATRIX_SIZE-1:0] enable_mult;
  logic                   result_valid;
  logic [ROW_W-1:0]       result_row;
  logic                   finished;

  // Host/source/sink side.
  modport master (
    output start,
    output input_ready,
    output output_ready,
    input  module_ready,
    input  load_weight,
    input  skew_enable,
    input  enable_mult,
    input  result_valid,
    input  result_row,
    input  finished
  );

  // Controller side.
  modport slave (
    input  start,
    input  input_ready,
    input  output_ready,
    output module_ready,
    output load_weight,
    output skew_enable,
    output enable_mult,
    output result_valid,
    output result_row,
    output finished
  );
endinterface

// File: rtl/matmul_job_controller.sv
// rtl/matmul_job_controller.sv - phase sequencer for one weight-stationary NxN systolic job
module matmul_job_controller #(
  parameter int MATRIX_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  matmul_job_controller_if.slave  job
);
  localparam int CNT_W = $clog2(2 * MATRIX_SIZE) + 1;
  localparam int ROW_W = $clog2(MATRIX_SIZE);

  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * MATRIX_SIZE - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic advance;
  logic mult_on;
  logic [MATRIX_SIZE-1:0] one_hot;

  assign accept  = (state == LOAD_W) && job.input_ready;
  assign advance = (state == STREAM) && job.input_ready && job.output_ready;
  assign one_hot = MATRIX_SIZE'(1) << cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job.start) begin
            state <= LOAD_W;
            cnt   <= '0;
          end
        end
        LOAD_W: begin
          if (job.input_ready) begin
            if (cnt == LAST_ROW) begin
              state <= STREAM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (job.input_ready && job.output_ready) begin
            if (cnt == LAST_ROW) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // The last data row needs 2N-1 extra cycles to ripple through the skew and the array.
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= OUTPUT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (job.output_ready) begin
            if (cnt == LAST_ROW) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decodes of registered state; the handshake terms add no latency.
  assign mult_on          = advance || (state == DRAIN);
  assign job.module_ready = (state == IDLE);
  assign job.load_weight  = accept ? one_hot : '0;
  assign job.skew_enable  = mult_on;
  assign job.enable_mult  = {MATRIX_SIZE{mult_on}};
  assign job.result_valid = (state == OUTPUT);
  assign job.result_row   = (state == OUTPUT) ? cnt[ROW_W-1:0] : '0;
  assign job.finished     = (state == DONE);
endmodule

// File: tb/tb_matmul_job_controller.sv
// tb/tb_matmul_job_controller.sv - scoreboard bench for matmul_job_controller (N=2 and N=4)
module tb_matmul_job_controller;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_job_controller_if #(.MATRIX_SIZE(2)) if2 ();
  matmul_job_controller_if #(.MATRIX_SIZE(4)) if4 ();

  matmul_job_controller #(.MATRIX_SIZE(2)) dut2 (.clk(clk), .reset(reset), .job(if2.slave));
  matmul_job_controller #(.MATRIX_SIZE(4)) dut4 (.clk(clk), .reset(reset), .job(if4.slave));

  typedef struct {
    int         c;
    logic [3:0] lw;
    logic       sk;
    logic [3:0] em;
    logic       rv;
    logic [1:0] row;
    logic       fin;
    logic       mr;
  } ev_t;

  ev_t  q2[$];
  ev_t  q4[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_mr[2];

  task automatic ex(input bit b4, input int c, input logic [3:0] lw, input logic sk,
                    input logic [3:0] em, input logic rv, input logic [1:0] row,
                    input logic fin, input logic mr);
    ev_t e;
    e.c = c; e.lw = lw; e.sk = sk; e.em = em; e.rv = rv; e.row = row; e.fin = fin; e.mr = mr;
    if (b4) q4.push_back(e);
    else    q2.push_back(e);
  endtask

  // Canonical N=2 job with every ready held high, start sampled at cycle t.
  task automatic std_job_n2(input int t);
    ex(0, t+1,  4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    ex(0, t+2,  4'b0010, 0, 4'b0000, 0, 0, 0, 0);
    for (int k = 3; k <= 7; k++) ex(0, t+k, 4'b0000, 1, 4'b0011, 0, 0, 0, 0);
    ex(0, t+8,  4'b0000, 0, 4'b0000, 1, 0, 0, 0);
    ex(0, t+9,  4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    ex(0, t+10, 4'b0000, 0, 4'b0000, 0, 0, 1, 0);
    ex(0, t+11, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
  endtask

  task automatic observe(input bit b4, input logic [3:0] lw, input logic sk, input logic [3:0] em,
                         input logic rv, input logic [1:0] row, input logic fin, input logic mr);
    ev_t e;
    string nm;
    nm = b4 ? "n4" : "n2";
    n_checks++;
    if ($countones(lw) > 1 || (lw != 0 && em != 0)) begin
      n_fail++;
      $display("FAIL %s_invariant cyc=%0d lw=%b em=%b required onehot lw and no lw/em overlap", nm, cyc, lw, em);
    end
    if (lw != 0 || sk || em != 0 || rv || fin || mr !== prev_mr[b4]) begin
      n_checks++;
      if ((b4 ? q4.size() : q2.size()) == 0) begin
        n_fail++;
        $display("FAIL %s_unexpected cyc=%0d lw=%b sk=%b em=%b rv=%b row=%0d fin=%b mr=%b required no event",
                 nm, cyc, lw, sk, em, rv, row, fin, mr);
      end else begin
        e = b4 ? q4.pop_front() : q2.pop_front();
        if (e.c != cyc || e.lw !== lw || e.sk !== sk || e.em !== em || e.rv !== rv ||
            e.row !== row || e.fin !== fin || e.mr !== mr) begin
          n_fail++;
          $display("FAIL %s_event actual cyc=%0d lw=%b sk=%b em=%b rv=%b row=%0d fin=%b mr=%b required cyc=%0d lw=%b sk=%b em=%b rv=%b row=%0d fin=%b mr=%b",
                   nm, cyc, lw, sk, em, rv, row, fin, mr, e.c, e.lw, e.sk, e.em, e.rv, e.row, e.fin, e.mr);
        end
      end
    end
    prev_mr[b4] = mr;
  endtask

  always @(negedge clk) begin
    observe(0, {2'b00, if2.load_weight}, if2.skew_enable, {2'b00, if2.enable_mult},
            if2.result_valid, {1'b0, if2.result_row}, if2.finished, if2.module_ready);
    observe(1, if4.load_weight, if4.skew_enable, if4.enable_mult,
            if4.result_valid, if4.result_row, if4.finished, if4.module_ready);
  end

  task automatic drive(input logic r, input logic s, input logic ir, input logic orr, input bit sel4);
    reset = r;
    if2.start = sel4 ? 1'b0 : s;  if2.input_ready = sel4 ? 1'b0 : ir;  if2.output_ready = sel4 ? 1'b0 : orr;
    if4.start = sel4 ? s : 1'b0;  if4.input_ready = sel4 ? ir : 1'b0;  if4.output_ready = sel4 ? orr : 1'b0;
    @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    prev_mr[0] = 1'b0;
    prev_mr[1] = 1'b0;
    reset = 1'b1;
    if2.start = 0; if2.input_ready = 0; if2.output_ready = 0;
    if4.start = 0; if4.input_ready = 0; if4.output_ready = 0;
    ex(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    ex(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Test 1: back-to-back readies.
    t0 = cyc;
    std_job_n2(t0);
    drive(0, 1, 1, 1, 0);
    repeat (13) drive(0, 0, 1, 1, 0);

    // Test 2: input_ready stalls weight load at cycles 2-3.
    t0 = cyc;
    ex(0, t0+1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    ex(0, t0+4, 4'b0010, 0, 4'b0000, 0, 0, 0, 0);
    for (int k = 5; k <= 9; k++) ex(0, t0+k, 4'b0000, 1, 4'b0011, 0, 0, 0, 0);
    ex(0, t0+10, 4'b0000, 0, 4'b0000, 1, 0, 0, 0);
    ex(0, t0+11, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    ex(0, t0+12, 4'b0000, 0, 4'b0000, 0, 0, 1, 0);
    ex(0, t0+13, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    for (int c = 0; c < 16; c++) drive(0, c == 0, !(c == 2 || c == 3), 1, 0);

    // Test 3: output_ready stalls streaming (3 cycles) and row 1 hand-off (2 cycles).
    t0 = cyc;
    ex(0, t0+1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    ex(0, t0+2, 4'b0010, 0, 4'b0000, 0, 0, 0, 0);
    for (int k = 6; k <= 10; k++) ex(0, t0+k, 4'b0000, 1, 4'b0011, 0, 0, 0, 0);
    ex(0, t0+11, 4'b0000, 0, 4'b0000, 1, 0, 0, 0);
    for (int k = 12; k <= 14; k++) ex(0, t0+k, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    ex(0, t0+15, 4'b0000, 0, 4'b0000, 0, 0, 1, 0);
    ex(0, t0+16, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    for (int c = 0; c < 19; c++)
      drive(0, c == 0, 1, !(c == 3 || c == 4 || c == 5 || c == 12 || c == 13), 0);

    // Test 4: start held through the job and DONE restarts from IDLE; busy pulses are ignored.
    t0 = cyc;
    std_job_n2(t0);
    std_job_n2(t0 + 11);
    for (int c = 0; c < 25; c++) drive(0, c <= 11 || c == 15 || c == 18, 1, 1, 0);

    // Test 5: reset during DRAIN aborts silently, then a fresh job runs.
    t0 = cyc;
    ex(0, t0+1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    ex(0, t0+2, 4'b0010, 0, 4'b0000, 0, 0, 0, 0);
    for (int k = 3; k <= 6; k++) ex(0, t0+k, 4'b0000, 1, 4'b0011, 0, 0, 0, 0);
    ex(0, t0+7, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    for (int c = 0; c < 8; c++) drive(c == 6, c == 0, 1, 1, 0);
    t0 = cyc;
    std_job_n2(t0);
    drive(0, 1, 1, 1, 0);
    repeat (13) drive(0, 0, 1, 1, 0);

    // Test 6: N=4 with all readies high.
    t0 = cyc;
    ex(1, t0+1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    ex(1, t0+2, 4'b0010, 0, 4'b0000, 0, 0, 0, 0);
    ex(1, t0+3, 4'b0100, 0, 4'b0000, 0, 0, 0, 0);
    ex(1, t0+4, 4'b1000, 0, 4'b0000, 0, 0, 0, 0);
    for (int k = 5; k <= 15; k++) ex(1, t0+k, 4'b0000, 1, 4'b1111, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) ex(1, t0+16+k, 4'b0000, 0, 4'b0000, 1, 2'(k), 0, 0);
    ex(1, t0+20, 4'b0000, 0, 4'b0000, 0, 0, 1, 0);
    ex(1, t0+21, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
    for (int c = 0; c < 24; c++) drive(0, c == 0, 1, 1, 1);

    repeat (3) drive(0, 0, 0, 0, 0);
    n_checks++;
    if (q2.size() != 0) begin
      n_fail++;
      $display("FAIL n2_pending events_left=%0d required 0", q2.size());
    end
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL n4_pending events_left=%0d required 0", q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
